// File: rtl/datapath_param_pkg.sv
// Shared encodings for the parametrised 8051-style datapath: ALU ops, ACC sources,
// jump conditions, stack sequencer states and PSW bit positions.
package datapath_param_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_ADDC = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5,
        ALU_INC  = 3'd6,
        ALU_PASS = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_RAM = 2'd1,
        SRC_REG = 2'd2,
        SRC_IMM = 2'd3
    } acc_src_e;

    typedef enum logic [1:0] {
        JC_ALWAYS = 2'd0,
        JC_Z      = 2'd1,
        JC_NZ     = 2'd2,
        JC_NC     = 2'd3
    } jmp_cond_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUSH    = 3'd1,
        ST_VECTOR  = 3'd2,
        ST_POP     = 3'd3,
        ST_POPWAIT = 3'd4
    } seq_state_e;

    // PSW flags are counted down from the MSB: {C, Z, 0...}
    localparam int PSW_C_FROM_MSB = 0;
    localparam int PSW_Z_FROM_MSB = 1;

endpackage

// File: rtl/datapath_param_alu.sv
// Combinational ALU; result carries one extra bit holding carry (or borrow for SUB).
module dp_alu
    import datapath_param_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cin_i,
    input  logic [2:0]        op_i,
    output logic [DATA_W:0]   result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = {1'b0, a_i} + {1'b0, b_i};
            ALU_ADDC: result_o = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cin_i};
            ALU_SUB:  result_o = {1'b0, a_i} - {1'b0, b_i};
            ALU_AND:  result_o = {1'b0, a_i & b_i};
            ALU_OR:   result_o = {1'b0, a_i | b_i};
            ALU_XOR:  result_o = {1'b0, a_i ^ b_i};
            ALU_INC:  result_o = {1'b0, a_i} + (DATA_W + 1)'(1);
            ALU_PASS: result_o = {1'b0, b_i};
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/datapath_param.sv
// Core datapath (IR, ACC, PSW, register bank, PC) with a stack sequencer that pushes the
// PC on interrupt entry and pops it on return through an external 1-cycle-latency stack RAM.
module datapath_param
    import datapath_param_pkg::*;
#(
    parameter  int DATA_W      = 8,
    parameter  int PC_W        = 16,
    parameter  int NREGS       = 8,
    parameter  int STACK_DEPTH = 16,
    localparam int SP_W        = $clog2(STACK_DEPTH) + 1,
    localparam int REG_W       = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] rom_byte,
    input  logic [DATA_W-1:0] ram_rd_byte,
    input  logic              ir_load_high,
    input  logic              ir_load_low,
    input  logic              acc_load,
    input  logic [1:0]        acc_src,
    input  logic [2:0]        alu_op,
    input  logic              alu_b_sel,
    input  logic              reg_wr_en,
    input  logic [REG_W-1:0]  reg_sel,
    input  logic              ram_rd_en,
    input  logic              ram_wr_en,
    input  logic              pc_inc,
    input  logic              pc_inc_offset,
    input  logic              pc_jmp,
    input  logic [1:0]        jmp_cond,
    input  logic              ret_req,
    input  logic              int_req,
    input  logic [PC_W-1:0]   int_vec,
    input  logic [DATA_W-1:0] stack_rd_data,
    output logic [DATA_W-1:0] opcode,
    output logic [PC_W-1:0]   rom_addr,
    output logic [DATA_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_wr_strobe,
    output logic [SP_W-2:0]   stack_addr,
    output logic              stack_wr_en,
    output logic [DATA_W-1:0] stack_wr_data,
    output logic [DATA_W-1:0] psw,
    output logic              busy,
    output logic              int_ack,
    output logic              stack_err
);

    localparam int BEATS  = PC_W / DATA_W;
    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BEATS - 1);
    localparam logic [SP_W-1:0]   SP_FULL   = SP_W'(STACK_DEPTH);

    logic [2*DATA_W-1:0] ir_q;
    logic [DATA_W-1:0]   acc_q;
    logic                c_q, z_q;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                err_q, err_d;
    logic                pop_bad_q, pop_bad_d;
    seq_state_e          state_q, state_d;

    logic                idle;
    logic [DATA_W-1:0]   ir_lo, reg_rd, alu_b, acc_next;
    logic [DATA_W:0]     alu_res;
    logic                cond_true;
    logic [PC_W-1:0]     pc_plus1, pc_rel, pop_word;
    logic [SP_W-1:0]     sp_dec;
    logic                pop_capture;
    logic [DATA_W-1:0]   pc_beats [BEATS];

    assign idle     = (state_q == ST_IDLE);
    assign ir_lo    = ir_q[DATA_W-1:0];
    assign reg_rd   = regs_q[reg_sel];
    assign alu_b    = alu_b_sel ? reg_rd : ir_lo;
    assign pc_plus1 = pc_q + PC_W'(1);
    assign pc_rel   = pc_plus1 + PC_W'($signed(ir_lo));
    assign sp_dec   = sp_q - SP_W'(1);

    dp_alu #(.DATA_W(DATA_W)) u_alu (
        .a_i      (acc_q),
        .b_i      (alu_b),
        .cin_i    (c_q),
        .op_i     (alu_op),
        .result_o (alu_res)
    );

    always_comb begin
        acc_next = alu_res[DATA_W-1:0];
        case (acc_src)
            SRC_ALU: acc_next = alu_res[DATA_W-1:0];
            SRC_RAM: acc_next = ram_rd_byte;
            SRC_REG: acc_next = reg_rd;
            SRC_IMM: acc_next = ir_lo;
            default: acc_next = alu_res[DATA_W-1:0];
        endcase
    end

    always_comb begin
        cond_true = 1'b0;
        case (jmp_cond)
            JC_ALWAYS: cond_true = 1'b1;
            JC_Z:      cond_true = z_q;
            JC_NZ:     cond_true = !z_q;
            JC_NC:     cond_true = !c_q;
            default:   cond_true = 1'b0;
        endcase
    end

    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beats
        assign pc_beats[gi] = pc_q[gi*DATA_W +: DATA_W];
    end

    // Popped beats arrive MSB first; shift them up so the last read lands in the LSB beat.
    if (BEATS > 1) begin : g_popbuf
        logic [PC_W-DATA_W-1:0] buf_q;
        always_ff @(posedge clock) begin
            if (reset)            buf_q <= '0;
            else if (pop_capture) buf_q <= pop_word[PC_W-DATA_W-1:0];
        end
        assign pop_word = {buf_q, stack_rd_data};
    end else begin : g_nobuf
        assign pop_word = stack_rd_data;
    end

    always_comb begin
        state_d       = state_q;
        sp_d          = sp_q;
        bcnt_d        = bcnt_q;
        pc_d          = pc_q;
        err_d         = err_q;
        pop_bad_d     = pop_bad_q;
        pop_capture   = 1'b0;
        stack_addr    = '0;
        stack_wr_en   = 1'b0;
        stack_wr_data = '0;
        int_ack       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bcnt_d    = '0;
                pop_bad_d = 1'b0;
                if (int_req)            state_d = ST_PUSH;
                else if (ret_req)       state_d = ST_POP;
                else if (pc_jmp)        pc_d    = cond_true ? pc_rel : pc_plus1;
                else if (pc_inc_offset) pc_d    = pc_rel;
                else if (pc_inc)        pc_d    = pc_plus1;
            end
            ST_PUSH: begin
                stack_wr_data = pc_beats[bcnt_q];
                if (sp_q == SP_FULL) begin
                    err_d = 1'b1;
                end else begin
                    stack_addr  = sp_q[SP_W-2:0];
                    stack_wr_en = 1'b1;
                    sp_d        = sp_q + SP_W'(1);
                end
                if (bcnt_q == BCNT_LAST) state_d = ST_VECTOR;
                else                     bcnt_d  = bcnt_q + BCNT_W'(1);
            end
            ST_VECTOR: begin
                pc_d    = int_vec;
                int_ack = 1'b1;
                state_d = ST_IDLE;
            end
            ST_POP: begin
                pop_capture = (bcnt_q != '0);
                if (sp_q == '0) begin
                    err_d     = 1'b1;
                    pop_bad_d = 1'b1;
                end else begin
                    stack_addr = sp_dec[SP_W-2:0];
                    sp_d       = sp_dec;
                end
                if (bcnt_q == BCNT_LAST) state_d = ST_POPWAIT;
                else                     bcnt_d  = bcnt_q + BCNT_W'(1);
            end
            ST_POPWAIT: begin
                if (!pop_bad_q) pc_d = pop_word;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            sp_q      <= '0;
            bcnt_q    <= '0;
            err_q     <= 1'b0;
            pop_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sp_q      <= sp_d;
            bcnt_q    <= bcnt_d;
            err_q     <= err_d;
            pop_bad_q <= pop_bad_d;
        end
    end

    // Datapath state only moves while the sequencer is idle; the control unit stalls otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q  <= '0;
            acc_q <= '0;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (idle) begin
            if (ir_load_high) ir_q[2*DATA_W-1:DATA_W] <= rom_byte;
            if (ir_load_low)  ir_q[DATA_W-1:0]        <= rom_byte;
            if (acc_load) begin
                acc_q <= acc_next;
                z_q   <= (acc_next == '0);
                if (acc_src == SRC_ALU) c_q <= alu_res[DATA_W];
            end
            if (reg_wr_en) regs_q[reg_sel] <= acc_q;
        end
    end

    assign opcode        = ir_q[2*DATA_W-1:DATA_W];
    assign rom_addr      = pc_q;
    assign ram_addr      = (ram_rd_en || ram_wr_en) ? ir_lo : '0;
    assign ram_wr_data   = ram_wr_en ? acc_q : '0;
    assign ram_wr_strobe = ram_wr_en;
    assign busy          = !idle;
    assign stack_err     = err_q;

    always_comb begin
        psw = '0;
        psw[DATA_W-1-PSW_C_FROM_MSB] = c_q;
        psw[DATA_W-1-PSW_Z_FROM_MSB] = z_q;
    end

endmodule
